// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage RISC-V immediate encoder with range/alignment error flag
//
// Ports:
//   clk         single clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    request valid
//   in_ready    request accepted when in_valid && in_ready
//   immsrc      format select: 00 I, 01 S, 10 B, 11 J
//   imm         signed immediate (byte offset for B/J)
//   base_instr  opcode/register/funct bits; immediate field bits are overwritten
//   out_valid   encoded instruction valid
//   out_ready   consumer accepts when out_valid && out_ready
//   instr       encoded instruction
//   err         immediate out of range or misaligned (encoding still emitted)
//   err_count   saturating count of delivered err=1 results
module imm_encoder #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           immsrc,
  input  logic [31:0]          imm,
  input  logic [31:0]          base_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic        s1_valid;
  logic [1:0]  s1_immsrc;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;

  logic        s2_ready;
  logic        s1_advance;
  logic        accept;
  logic [31:0] enc;
  logic        enc_err;

  // Stage 2 can take a new result when empty or when its current one leaves.
  assign s2_ready   = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;

  // Range check: the bits above the encodable sign bit must all be copies of it.
  always_comb begin
    enc     = s1_base;
    enc_err = 1'b0;
    case (s1_immsrc)
      2'b00: begin
        enc[31:20] = s1_imm[11:0];
        enc_err    = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      2'b01: begin
        enc[31:25] = s1_imm[11:5];
        enc[11:7]  = s1_imm[4:0];
        enc_err    = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      2'b10: begin
        enc[31]    = s1_imm[12];
        enc[30:25] = s1_imm[10:5];
        enc[11:8]  = s1_imm[4:1];
        enc[7]     = s1_imm[11];
        enc_err    = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
      end
      default: begin
        enc[31]    = s1_imm[20];
        enc[30:21] = s1_imm[10:1];
        enc[20]    = s1_imm[11];
        enc[19:12] = s1_imm[19:12];
        enc_err    = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
      end
    endcase
  end

  // Stage 1: request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_immsrc <= 2'b00;
      s1_imm    <= 32'h0;
      s1_base   <= 32'h0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_immsrc <= immsrc;
        s1_imm    <= imm;
        s1_base   <= base_instr;
      end else if (s1_advance) begin
        s1_valid  <= 1'b0;
      end
    end
  end

  // Stage 2: result register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= 32'h0;
      err       <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instr <= enc;
        err   <= enc_err;
      end
    end
  end

  // Counted on the delivering handshake only, so stalls never double count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && err && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, 8, width of saturating error counter.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have port: immsrc  input  2  format: 00 I, 01 S, 10 B, 11 J.
REQ-007 SHALL have port: imm  input  32  signed immediate value, byte offset for B/J.
REQ-008 SHALL have port: base_instr  input  32  opcode/register/funct bits; immediate field bits ignored.
REQ-009 SHALL have port: out_valid  output  1  encoded instruction valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-011 SHALL have port: instr  output  32  encoded instruction.
REQ-012 SHALL have port: err  output  1  qualifies instr: immediate out of range or misaligned.
REQ-013 SHALL have port: err_count  output  CNT_WIDTH  saturating count of delivered err=1 results.

Function
REQ-014 SHALL be a two-stage pipeline: stage 1 registers request; stage 2 registers encoded result onto instr/err/out_valid.
REQ-015 SHALL present a request accepted in cycle N on the outputs in cycle N+2 when out_ready is held high; throughput one per cycle.
REQ-016 SHALL hold stage 2 contents stable while out_valid && !out_ready; stage 1 advances only when stage 2 is empty or draining.
REQ-017 SHALL drive in_ready = !s1_valid || s1_advance; no request is dropped or duplicated under any out_ready pattern.
REQ-018 SHALL encode I: instr[31:20]=imm[11:0]; other bits from base_instr.
REQ-019 SHALL encode S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; other bits from base_instr.
REQ-020 SHALL encode B: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; other bits from base_instr.
REQ-021 SHALL encode J: instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; other bits from base_instr.
REQ-022 SHALL set err for I/S when imm[31:11] not all equal; for B when imm[31:12] not all equal or imm[0]=1; for J when imm[31:20] not all equal or imm[0]=1.
REQ-023 SHALL still emit the truncated encoding when err=1 (no suppression).
REQ-024 SHALL increment err_count by one per output handshake with err=1, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-025 SHALL not change err_count on stalled cycles (out_valid && !out_ready).
REQ-026 SHALL produce the same result regardless of base_instr bits lying in the selected immediate fields.

Reset
REQ-027 SHALL on rst_n low immediately clear s1_valid, out_valid, err, err_count; drive instr=0; in_ready=1 during and after reset.
REQ-028 SHALL discard any in-flight request when reset asserts mid-operation; no output follows release.
REQ-029 SHALL accept a request on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 SHALL verify I: immsrc=00, imm=0xFFFFFFFF, base_instr=0x00000013 -> instr=0xFFF00013, err=0, two cycles later.
REQ-031 SHALL verify B and J: immsrc=10, imm=0x10, base=0x00000063 -> 0x00000863, err=0; immsrc=11, imm=0x800, base=0x0000006F -> 0x0010006F, err=0.
REQ-032 SHALL verify errors: immsrc=00, imm=0x800, base=0x13 -> instr=0x80000013, err=1, err_count=1; immsrc=10, imm=3 -> err=1, err_count=2.
REQ-033 SHALL verify backpressure: 4 back-to-back requests, out_ready low 3 cycles -> in_ready low after 2 accepted, outputs held, all 4 delivered in order.
REQ-034 SHALL verify saturation: 260 erroring requests with CNT_WIDTH=8 -> err_count=255, stays 255.
REQ-035 SHALL verify reset mid-flight: rst_n low with both stages full -> out_valid=0 immediately, err_count=0, no stale output after release.
